// File: rtl/nn_sequencer.sv
// nn_sequencer: IDLE/FETCH/EXEC microsequencer that decodes instruction words into MAC datapath controls.
// Define NN_SEQ_LOOP_EN to compile in the single-level LOOP/ENDLOOP hardware loop.
module nn_sequencer #(
  parameter int NU_COUNT   = 8,
  parameter int INST_DEPTH = 256,
  parameter int CNT_W      = 8,
  parameter int ADDR_W     = 10,
  parameter int INST_W     = 4 + CNT_W + ADDR_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [INST_W-1:0]             inst_data,
  output logic [$clog2(INST_DEPTH)-1:0] inst_addr,
  output logic                          busy,
  output logic                          done,
  output logic [NU_COUNT-1:0]           mac_reg_enable,
  output logic                          mac_acc_loopback,
  output logic                          mac_x_select,
  output logic                          mac_w_select,
  output logic                          serializer_update,
  output logic                          act_input_select,
  output logic [ADDR_W-1:0]             xy_read_addr,
  output logic [ADDR_W-1:0]             xy_write_addr,
  output logic [ADDR_W-1:0]             w_read_addr,
  output logic [ADDR_W-1:0]             w_write_addr,
  output logic                          xy_write_enable,
  output logic                          w_write_enable,
  output logic [1:0]                    fsm_state
);

  localparam int IA_W = $clog2(INST_DEPTH);

  localparam logic [3:0] OP_SETW      = 4'h1;
  localparam logic [3:0] OP_MATMUL    = 4'h2;
  localparam logic [3:0] OP_ACCMOV    = 4'h3;
  localparam logic [3:0] OP_LOADMAC   = 4'h4;
  localparam logic [3:0] OP_VECTTOMAT = 4'h5;
  localparam logic [3:0] OP_WACC      = 4'h6;
`ifdef NN_SEQ_LOOP_EN
  localparam logic [3:0] OP_LOOP      = 4'h7;
  localparam logic [3:0] OP_ENDLOOP   = 4'h8;
`endif
  localparam logic [3:0] OP_HALT      = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [IA_W-1:0]     pc, pc_next, pc_inc;
  logic [INST_W-1:0]   ir;
  logic [CNT_W-1:0]    i, i_next;
  logic [ADDR_W-1:0]   wptr, wptr_next;
`ifdef NN_SEQ_LOOP_EN
  logic [IA_W-1:0]     loop_start, loop_start_next;
  logic [CNT_W-1:0]    loop_cnt, loop_cnt_next;
`endif

  logic [3:0]          op;
  logic [CNT_W-1:0]    op_cnt;
  logic [ADDR_W-1:0]   opnd;
  logic [ADDR_W-1:0]   i_ext, x_addr, w_addr;
  logic                single_cycle, last_cycle;

  assign op     = ir[INST_W-1 -: 4];
  assign op_cnt = ir[ADDR_W +: CNT_W];
  assign opnd   = ir[ADDR_W-1:0];

  // Address sums are truncated to ADDR_W, so they wrap naturally.
  assign i_ext  = ADDR_W'(i);
  assign x_addr = opnd + i_ext;
  assign w_addr = wptr + i_ext;

  assign pc_inc = (pc == IA_W'(INST_DEPTH - 1)) ? '0 : pc + IA_W'(1);

  always_comb begin
    single_cycle = (op == OP_SETW) || (op == OP_HALT);
`ifdef NN_SEQ_LOOP_EN
    if ((op == OP_LOOP) || (op == OP_ENDLOOP)) single_cycle = 1'b1;
`endif
    last_cycle = single_cycle || (i == op_cnt);
  end

  // Handshake: start is a level sampled only in IDLE; a start seen while busy is dropped,
  // and there is no acknowledge other than busy rising on the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      i          <= '0;
      wptr       <= '0;
`ifdef NN_SEQ_LOOP_EN
      loop_start <= '0;
      loop_cnt   <= '0;
`endif
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      i          <= i_next;
      wptr       <= wptr_next;
`ifdef NN_SEQ_LOOP_EN
      loop_start <= loop_start_next;
      loop_cnt   <= loop_cnt_next;
`endif
      if (state == S_FETCH) ir <= inst_data;
    end
  end

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    i_next          = i;
    wptr_next       = wptr;
`ifdef NN_SEQ_LOOP_EN
    loop_start_next = loop_start;
    loop_cnt_next   = loop_cnt;
`endif
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
          pc_next    = '0;
        end
      end
      S_FETCH: begin
        state_next = S_EXEC;
        i_next     = '0;
      end
      S_EXEC: begin
        if (op == OP_SETW) wptr_next = opnd;
`ifdef NN_SEQ_LOOP_EN
        if (op == OP_LOOP) begin
          loop_start_next = pc_inc;
          loop_cnt_next   = op_cnt;
        end
`endif
        if (op == OP_HALT) begin
          state_next = S_IDLE;
        end else if (last_cycle) begin
          state_next = S_FETCH;
          pc_next    = pc_inc;
`ifdef NN_SEQ_LOOP_EN
          if ((op == OP_ENDLOOP) && (loop_cnt != '0)) begin
            loop_cnt_next = loop_cnt - CNT_W'(1);
            pc_next       = loop_start;
          end
`endif
        end else begin
          i_next = i + CNT_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The fetch address is the value the program counter takes at this edge, so the
  // one-cycle instruction memory has the word ready by the end of FETCH.
  assign inst_addr = pc_next;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_EXEC) && (op == OP_HALT);
  assign fsm_state = state;

  always_comb begin
    mac_reg_enable    = '0;
    mac_acc_loopback  = 1'b0;
    mac_x_select      = 1'b0;
    mac_w_select      = 1'b0;
    serializer_update = 1'b0;
    act_input_select  = 1'b0;
    xy_read_addr      = '0;
    xy_write_addr     = '0;
    w_read_addr       = '0;
    w_write_addr      = '0;
    xy_write_enable   = 1'b0;
    w_write_enable    = 1'b0;
    if (state == S_EXEC) begin
      case (op)
        OP_MATMUL: begin
          xy_read_addr      = x_addr;
          w_read_addr       = w_addr;
          mac_x_select      = 1'b1;
          mac_w_select      = 1'b1;
          serializer_update = 1'b1;
          mac_acc_loopback  = (i != '0);
        end
        OP_ACCMOV: begin
          act_input_select = 1'b1;
          xy_write_enable  = 1'b1;
          xy_write_addr    = x_addr;
        end
        OP_LOADMAC: begin
          for (int k = 0; k < NU_COUNT; k++) begin
            mac_reg_enable[k] = (x_addr == ADDR_W'(k));
          end
        end
        OP_VECTTOMAT: begin
          xy_read_addr   = x_addr;
          w_write_enable = 1'b1;
          w_write_addr   = w_addr;
        end
        OP_WACC: begin
          mac_x_select     = 1'b1;
          mac_w_select     = 1'b1;
          mac_acc_loopback = 1'b1;
          w_read_addr      = w_addr;
          w_write_addr     = w_addr;
          w_write_enable   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_sequencer.sv
// Self-checking bench for nn_sequencer: directed vector table, hand-built corner sequences,
// and random programs compared cycle-by-cycle against a program-level reference model.
module tb_nn_sequencer;

  localparam int NU_COUNT   = 8;
  localparam int INST_DEPTH = 256;
  localparam int CNT_W      = 8;
  localparam int ADDR_W     = 10;
  localparam int INST_W     = 4 + CNT_W + ADDR_W;

  localparam int F_XYR  = 0;
  localparam int F_LOOP = 1;
  localparam int F_DONE = 2;
  localparam int F_BUSY = 3;
  localparam int F_WWA  = 4;
  localparam int F_WWE  = 5;
  localparam int F_MAC  = 6;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [7:0] mac;
    logic       loopback;
    logic       xsel;
    logic       wsel;
    logic       ser;
    logic       act;
    logic [9:0] xyr;
    logic [9:0] xyw;
    logic [9:0] wr;
    logic [9:0] ww;
    logic       xywe;
    logic       wwe;
  } out_t;

  localparam int OUT_W = $bits(out_t);

  typedef struct {
    string name;
    int    prog;
    int    idx;
    int    fld;
    int    val;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [INST_W-1:0]    inst_data;
  logic [7:0]           inst_addr;
  logic                 busy, done;
  logic [NU_COUNT-1:0]  mac_reg_enable;
  logic                 mac_acc_loopback, mac_x_select, mac_w_select;
  logic                 serializer_update, act_input_select;
  logic [ADDR_W-1:0]    xy_read_addr, xy_write_addr, w_read_addr, w_write_addr;
  logic                 xy_write_enable, w_write_enable;
  logic [1:0]           fsm_state;

  logic [INST_W-1:0]    imem [INST_DEPTH];
  logic [OUT_W-1:0]     exp_q[$];
  out_t                 cap_q[$];
  out_t                 cap1[$];
  out_t                 cap2[$];
  vec_t                 vecs[$];

  int n_checks;
  int n_pass;
  int m_wptr, m_lstart, m_lcnt;

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  always @(posedge clk) inst_data <= imem[inst_addr];

  nn_sequencer #(
    .NU_COUNT(NU_COUNT), .INST_DEPTH(INST_DEPTH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .inst_data(inst_data), .inst_addr(inst_addr),
    .busy(busy), .done(done),
    .mac_reg_enable(mac_reg_enable), .mac_acc_loopback(mac_acc_loopback),
    .mac_x_select(mac_x_select), .mac_w_select(mac_w_select),
    .serializer_update(serializer_update), .act_input_select(act_input_select),
    .xy_read_addr(xy_read_addr), .xy_write_addr(xy_write_addr),
    .w_read_addr(w_read_addr), .w_write_addr(w_write_addr),
    .xy_write_enable(xy_write_enable), .w_write_enable(w_write_enable),
    .fsm_state(fsm_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [INST_W-1:0] mk(input int op, input int cnt, input int opnd);
    mk = {4'(op), 8'(cnt), 10'(opnd)};
  endfunction

  function automatic out_t sample();
    out_t r;
    r.busy = busy;               r.done = done;
    r.mac = mac_reg_enable;      r.loopback = mac_acc_loopback;
    r.xsel = mac_x_select;       r.wsel = mac_w_select;
    r.ser = serializer_update;   r.act = act_input_select;
    r.xyr = xy_read_addr;        r.xyw = xy_write_addr;
    r.wr = w_read_addr;          r.ww = w_write_addr;
    r.xywe = xy_write_enable;    r.wwe = w_write_enable;
    return r;
  endfunction

  function automatic int get_field(input out_t r, input int f);
    case (f)
      F_XYR:   return int'(r.xyr);
      F_LOOP:  return int'(r.loopback);
      F_DONE:  return int'(r.done);
      F_BUSY:  return int'(r.busy);
      F_WWA:   return int'(r.ww);
      F_WWE:   return int'(r.wwe);
      F_MAC:   return int'(r.mac);
      default: return -1;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic clear_imem();
    for (int a = 0; a < INST_DEPTH; a++) imem[a] = '0;
  endtask

  task automatic model_reset();
    m_wptr = 0; m_lstart = 0; m_lcnt = 0;
  endtask

  task automatic add_vec(input string name, input int prog, input int idx, input int fld, input int val);
    vec_t v;
    v.name = name; v.prog = prog; v.idx = idx; v.fld = fld; v.val = val;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  function automatic out_t exec_rec(input int op, input int opnd, input int i);
    out_t r;
    int   sx, sw;
    r = '0;
    r.busy = 1'b1;
    sx = (opnd + i) % 1024;
    sw = (m_wptr + i) % 1024;
    case (op)
      2: begin r.xyr = 10'(sx); r.wr = 10'(sw); r.xsel = 1'b1; r.wsel = 1'b1;
               r.ser = 1'b1; r.loopback = (i != 0); end
      3: begin r.act = 1'b1; r.xywe = 1'b1; r.xyw = 10'(sx); end
      4: if (sx < NU_COUNT) r.mac = 8'(1 << sx);
      5: begin r.xyr = 10'(sx); r.wwe = 1'b1; r.ww = 10'(sw); end
      6: begin r.xsel = 1'b1; r.wsel = 1'b1; r.loopback = 1'b1;
               r.wr = 10'(sw); r.ww = 10'(sw); r.wwe = 1'b1; end
      default: ;
    endcase
    return r;
  endfunction

  // Walks the program from address 0 and lists the expected output of every cycle:
  // one FETCH cycle per instruction, then its execute cycles, then two idle cycles after HALT.
  task automatic build_expected(output bit halted);
    int pc, op, cnt, opnd;
    logic [INST_W-1:0] w;
    out_t r;
    exp_q.delete();
    pc = 0;
    halted = 1'b0;
    while (!halted && exp_q.size() < 4000) begin
      w    = imem[pc];
      op   = int'(w[21:18]);
      cnt  = int'(w[17:10]);
      opnd = int'(w[9:0]);
      r = '0; r.busy = 1'b1;
      exp_q.push_back(r);
      if (op == 1) begin
        m_wptr = opnd;
        exp_q.push_back(r);
        pc = (pc + 1) % INST_DEPTH;
      end else if (op == 15) begin
        r.done = 1'b1;
        exp_q.push_back(r);
        halted = 1'b1;
      end
`ifdef NN_SEQ_LOOP_EN
      else if (op == 7) begin
        m_lstart = (pc + 1) % INST_DEPTH;
        m_lcnt   = cnt;
        exp_q.push_back(r);
        pc = (pc + 1) % INST_DEPTH;
      end else if (op == 8) begin
        exp_q.push_back(r);
        if (m_lcnt != 0) begin
          m_lcnt--;
          pc = m_lstart;
        end else begin
          pc = (pc + 1) % INST_DEPTH;
        end
      end
`endif
      else begin
        for (int i = 0; i <= cnt; i++) exp_q.push_back(exec_rec(op, opnd, i));
        pc = (pc + 1) % INST_DEPTH;
      end
    end
    r = '0;
    exp_q.push_back(r);
    exp_q.push_back(r);
  endtask

  // ---------------- driver ----------------
  task automatic run_prog(input string tag, input int restart_at);
    out_t a, e;
    bit   halted;
    build_expected(halted);
    if (!halted) begin
      n_checks++;
      $display("FAIL %s_model: program did not reach HALT within 4000 cycles", tag);
    end
    cap_q.delete();
    @(negedge clk);
    start = 1'b1;
    for (int n = 0; n < exp_q.size(); n++) begin
      @(negedge clk);
      start = (n == restart_at);
      a = sample();
      e = exp_q[n];
      cap_q.push_back(a);
      check($sformatf("%s[%0d]", tag, n), a, e);
    end
    start = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    int ops[10] = '{0, 1, 2, 3, 4, 5, 6, 9, 12, 14};
    int nb, nd, exp_busy, len, op, opnd;
    out_t r;

    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    clear_imem();
    model_reset();

    add_vec("mm_xyr_i0",     1, 1, F_XYR,  10);
    add_vec("mm_xyr_i1",     1, 2, F_XYR,  11);
    add_vec("mm_xyr_i2",     1, 3, F_XYR,  12);
    add_vec("mm_xyr_i3",     1, 4, F_XYR,  13);
    add_vec("mm_loop_i0",    1, 1, F_LOOP, 0);
    add_vec("mm_loop_i1",    1, 2, F_LOOP, 1);
    add_vec("mm_loop_i3",    1, 4, F_LOOP, 1);
    add_vec("mm_done_fetch", 1, 5, F_DONE, 0);
    add_vec("mm_done_halt",  1, 6, F_DONE, 1);
    add_vec("mm_busy_fetch", 1, 0, F_BUSY, 1);
    add_vec("mm_busy_after", 1, 7, F_BUSY, 0);
    add_vec("setw_one_cyc",  2, 2, F_WWE,  0);
    add_vec("vtm_wwa_i0",    2, 3, F_WWA,  'h3FE);
    add_vec("vtm_wwa_i1",    2, 4, F_WWA,  'h3FF);
    add_vec("vtm_wwa_i2",    2, 5, F_WWA,  'h000);
    add_vec("vtm_wwa_i3",    2, 6, F_WWA,  'h001);
    add_vec("vtm_wwe_i0",    2, 3, F_WWE,  1);
    add_vec("vtm_wwe_i3",    2, 6, F_WWE,  1);
    add_vec("vtm_wwe_end",   2, 7, F_WWE,  0);
    add_vec("lmac_i0",       2, 8, F_MAC,  'h40);
    add_vec("lmac_i1",       2, 9, F_MAC,  'h80);
    add_vec("lmac_i2",       2, 10, F_MAC, 'h00);
    add_vec("lmac_i3",       2, 11, F_MAC, 'h00);
    add_vec("p2_done",       2, 13, F_DONE, 1);
    add_vec("p2_busy_after", 2, 14, F_BUSY, 0);

    #2;
    r = '0;
    check("reset_outputs", sample(), r);
    check("reset_inst_addr", inst_addr, 0);
    check("reset_fsm_state", fsm_state, 0);
    #10 reset = 1'b0;

    // MATMUL count=3 opnd=10, HALT
    imem[0] = mk(2, 3, 10);
    imem[1] = mk(15, 0, 0);
    run_prog("matmul", -1);
    cap1 = cap_q;

    // SETW 0x3FE (count ignored), VECTTOMAT count=3, LOADMAC opnd=6 count=3, HALT
    clear_imem();
    imem[0] = mk(1, 5, 'h3FE);
    imem[1] = mk(5, 3, 20);
    imem[2] = mk(4, 3, 6);
    imem[3] = mk(15, 0, 0);
    run_prog("vtm_lmac", -1);
    cap2 = cap_q;

    for (int k = 0; k < vecs.size(); k++) begin
      r = (vecs[k].prog == 1) ? cap1[vecs[k].idx] : cap2[vecs[k].idx];
      check(vecs[k].name, get_field(r, vecs[k].fld), vecs[k].val);
    end

    // start pulsed again while busy must be ignored
    clear_imem();
    imem[0] = mk(2, 3, 10);
    imem[1] = mk(15, 0, 0);
    run_prog("start_busy", 2);

    // reset asserted in the second MATMUL execute cycle
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_xyr", xy_read_addr, 11);
    #1 reset = 1'b1;
    #1;
    r = '0;
    check("rst_mid_outputs", sample(), r);
    check("rst_mid_inst_addr", inst_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run_prog("restart", -1);

    // LOOP count=2, NOP, ENDLOOP, HALT
    clear_imem();
    imem[0] = mk(7, 2, 0);
    imem[1] = mk(0, 0, 0);
    imem[2] = mk(8, 0, 0);
    imem[3] = mk(15, 0, 0);
    run_prog("loop", -1);
    nb = 0;
    nd = 0;
    foreach (cap_q[k]) begin
      if (cap_q[k].busy) nb++;
      if (cap_q[k].done) nd++;
    end
`ifdef NN_SEQ_LOOP_EN
    exp_busy = 16;
`else
    exp_busy = 10;
`endif
    check("loop_busy_cycles", nb, exp_busy);
    check("loop_done_count", nd, 1);

    // random programs
    for (int p = 0; p < 8; p++) begin
      clear_imem();
      len = $urandom_range(3, 7);
      for (int k = 0; k < len; k++) begin
        op   = ops[$urandom_range(0, 9)];
        opnd = (op == 4) ? $urandom_range(0, 10) : $urandom_range(0, 1023);
        imem[k] = mk(op, $urandom_range(0, 3), opnd);
      end
      imem[len] = mk(15, 0, 0);
      run_prog($sformatf("rand%0d", p), (p == 3) ? 3 : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
